// File: rtl/reset_sequencer_if.sv
// Signal bundle between reset_sequencer and the subsystem it resets.
// Carries the soft-reset request, the sequenced resets, status, and a debug view of the FSM state.
`timescale 1ns/1ps

interface reset_sequencer_if #(
  parameter int NUM_CH = 2
);
  // sw_rst_req is a single-cycle request pulse with no acknowledge. It is
  // honoured only when sampled high in RUN. Outputs are level signals that
  // are valid on every cycle.
  logic              sw_rst_req;
  logic [NUM_CH-1:0] rst_n_out;
  logic              seq_done;
  logic              rst_cause;
  logic [1:0]        dbg_state;

  modport master (
    input  sw_rst_req,
    output rst_n_out,
    output seq_done,
    output rst_cause,
    output dbg_state
  );

  modport slave (
    output sw_rst_req,
    input  rst_n_out,
    input  seq_done,
    input  rst_cause,
    input  dbg_state
  );
endinterface

// File: rtl/reset_sequencer.sv
// Synchronised reset release with hold time and staggered per-domain release, memories before core.
// Optional soft reset and reset-cause tracking are built when RESET_SEQ_SOFT_RST_EN is defined.
`timescale 1ns/1ps

module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_CH      = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                  clk_core,
  input  logic                  async_reset_n,
  reset_sequencer_if.master     bus
);

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(NUM_CH) + 1;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_CH-1:0]  rst_q, rst_d;
  logic               done_q, done_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               rel_sync;

  // Release path only: assertion bypasses these flops via the async clear.
  always_ff @(posedge clk_core or negedge async_reset_n) begin
    if (!async_reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rel_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_core or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    done_d  = done_q;
    case (state_q)
      ST_ASSERT: begin
        if (rel_sync) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          rst_d[0] = 1'b1;
          if (NUM_CH == 1) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RELEASE;
            cnt_d   = CNT_W'(GAP_CYCLES - 1);
            idx_d   = IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (cnt_q == '0) begin
          // Decoded set avoids indexing with the wider channel index.
          for (int k = 0; k < NUM_CH; k++) begin
            if (idx_q == IDX_W'(k)) rst_d[k] = 1'b1;
          end
          if (idx_q == IDX_W'(NUM_CH - 1)) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            cnt_d = CNT_W'(GAP_CYCLES - 1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RUN: begin
`ifdef RESET_SEQ_SOFT_RST_EN
        // Soft reset skips the synchroniser: the request is already in clk_core.
        if (bus.sw_rst_req) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
          idx_d   = '0;
          rst_d   = '0;
          done_d  = 1'b0;
        end
`endif
      end
      default: begin
        state_d = ST_ASSERT;
      end
    endcase
  end

`ifdef RESET_SEQ_SOFT_RST_EN
  logic cause_q;

  always_ff @(posedge clk_core or negedge async_reset_n) begin
    if (!async_reset_n) begin
      cause_q <= 1'b0;
    end else if ((state_q == ST_RUN) && bus.sw_rst_req) begin
      cause_q <= 1'b1;
    end
  end

  assign bus.rst_cause = cause_q;
`else
  assign bus.rst_cause = 1'b0;
`endif

  assign bus.rst_n_out = rst_q;
  assign bus.seq_done  = done_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default instance (A) and a 4-channel instance (B) sharing clock and reset.
// An edge-count timing model predicts every output each cycle; directed literals pin the model.
`timescale 1ns/1ps

module tb_reset_sequencer;

  localparam int A_SYNC = 2, A_NCH = 2, A_HOLD = 16, A_GAP = 1;
  localparam int B_SYNC = 3, B_NCH = 4, B_HOLD = 4,  B_GAP = 3;

  // ---------------- clock / reset ----------------
  logic clk_core = 1'b0;
  logic async_reset_n;
  always #5 clk_core = ~clk_core;

  reset_sequencer_if #(.NUM_CH(A_NCH)) if_a ();
  reset_sequencer_if #(.NUM_CH(B_NCH)) if_b ();

  reset_sequencer #(
    .SYNC_STAGES(A_SYNC), .NUM_CH(A_NCH), .HOLD_CYCLES(A_HOLD), .GAP_CYCLES(A_GAP)
  ) dut_a (
    .clk_core      (clk_core),
    .async_reset_n (async_reset_n),
    .bus           (if_a)
  );

  reset_sequencer #(
    .SYNC_STAGES(B_SYNC), .NUM_CH(B_NCH), .HOLD_CYCLES(B_HOLD), .GAP_CYCLES(B_GAP)
  ) dut_b (
    .clk_core      (clk_core),
    .async_reset_n (async_reset_n),
    .bus           (if_b)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- timing model ----------------
  // Channel k is high once elapsed edges reach base + hold + k*gap.
  function automatic logic [15:0] exp_mask(input int elapsed, input int base, input int nch,
                                           input int hold, input int gap);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < nch; k++) begin
      if (elapsed >= 0 && elapsed >= base + hold + k * gap) r[k] = 1'b1;
    end
    return r;
  endfunction

  int   m_edges;
  int   s_edges;
  logic soft_mode;
  logic m_cause;

  function automatic logic [A_NCH-1:0] exp_a();
    logic [15:0] r;
    if (soft_mode) r = exp_mask(s_edges, 0, A_NCH, A_HOLD, A_GAP);
    else           r = exp_mask(m_edges, A_SYNC, A_NCH, A_HOLD, A_GAP);
    return r[A_NCH-1:0];
  endfunction

  function automatic logic [B_NCH-1:0] exp_b();
    logic [15:0] r;
    r = exp_mask(m_edges, B_SYNC, B_NCH, B_HOLD, B_GAP);
    return r[B_NCH-1:0];
  endfunction

  always @(posedge clk_core or negedge async_reset_n) begin
    if (!async_reset_n) begin
      m_edges   <= -1;
      s_edges   <= 0;
      soft_mode <= 1'b0;
      m_cause   <= 1'b0;
    end else begin
      m_edges <= m_edges + 1;
`ifdef RESET_SEQ_SOFT_RST_EN
      if (exp_a() == {A_NCH{1'b1}} && if_a.sw_rst_req) begin
        soft_mode <= 1'b1;
        s_edges   <= 0;
        m_cause   <= 1'b1;
      end else begin
        s_edges <= s_edges + 1;
      end
`endif
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk_core);
      check("cmp_a_rst",   if_a.rst_n_out, exp_a());
      check("cmp_a_done",  if_a.seq_done,  exp_a() == {A_NCH{1'b1}});
      check("cmp_a_cause", if_a.rst_cause, m_cause);
      check("cmp_b_rst",   if_b.rst_n_out, exp_b());
      check("cmp_b_done",  if_b.seq_done,  exp_b() == {B_NCH{1'b1}});
      check("cmp_b_cause", if_b.rst_cause, 1'b0);
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    async_reset_n   = 1'b0;
    if_a.sw_rst_req = 1'b0;
    if_b.sw_rst_req = 1'b0;
    repeat (3) @(posedge clk_core);
    @(negedge clk_core);
    check("rst_a_out",   if_a.rst_n_out, 2'b00);
    check("rst_a_done",  if_a.seq_done,  1'b0);
    check("rst_a_cause", if_a.rst_cause, 1'b0);
    check("rst_b_out",   if_b.rst_n_out, 4'b0000);

    // Power-on sequence; sw_rst_req held high through part of HOLD must not matter.
    async_reset_n = 1'b1;
    for (int m = 0; m <= 20; m++) begin
      @(posedge clk_core);
      #2;
      if (m == 3)  if_a.sw_rst_req = 1'b1;
      if (m == 15) if_a.sw_rst_req = 1'b0;
      @(negedge clk_core);
      case (m)
        6:  check("b_e6",  if_b.rst_n_out, 4'b0000);
        7:  check("b_e7",  if_b.rst_n_out, 4'b0001);
        10: check("b_e10", if_b.rst_n_out, 4'b0011);
        13: check("b_e13", if_b.rst_n_out, 4'b0111);
        15: check("b_e15_done", if_b.seq_done, 1'b0);
        16: begin
          check("b_e16", if_b.rst_n_out, 4'b1111);
          check("b_e16_done", if_b.seq_done, 1'b1);
        end
        17: check("a_e17", if_a.rst_n_out, 2'b00);
        18: begin
          check("a_e18", if_a.rst_n_out, 2'b01);
          check("a_e18_done", if_a.seq_done, 1'b0);
        end
        19: begin
          check("a_e19", if_a.rst_n_out, 2'b11);
          check("a_e19_done", if_a.seq_done, 1'b1);
          check("a_e19_cause", if_a.rst_cause, 1'b0);
        end
        default: ;
      endcase
    end

    // Soft-reset request pulse sampled in RUN at edge S.
    if_a.sw_rst_req = 1'b1;
    @(posedge clk_core);
    #2;
    if_a.sw_rst_req = 1'b0;
    @(negedge clk_core);
`ifdef RESET_SEQ_SOFT_RST_EN
    check("sw_s_out",   if_a.rst_n_out, 2'b00);
    check("sw_s_done",  if_a.seq_done,  1'b0);
    check("sw_s_cause", if_a.rst_cause, 1'b1);
`else
    check("sw_s_out",   if_a.rst_n_out, 2'b11);
    check("sw_s_done",  if_a.seq_done,  1'b1);
    check("sw_s_cause", if_a.rst_cause, 1'b0);
`endif
    check("sw_s_b", if_b.rst_n_out, 4'b1111);
    for (int n = 1; n <= 18; n++) begin
      @(posedge clk_core);
      @(negedge clk_core);
`ifdef RESET_SEQ_SOFT_RST_EN
      case (n)
        15: check("sw_s15", if_a.rst_n_out, 2'b00);
        16: check("sw_s16", if_a.rst_n_out, 2'b01);
        17: begin
          check("sw_s17", if_a.rst_n_out, 2'b11);
          check("sw_s17_cause", if_a.rst_cause, 1'b1);
        end
        default: ;
      endcase
`else
      if (n == 17) check("sw_s17", if_a.rst_n_out, 2'b11);
`endif
    end

    // Short async pulse while running: everything drops at once, cause clears.
    @(posedge clk_core);
    #2;
    async_reset_n = 1'b0;
    #0.5;
    check("pulse1_a_out",   if_a.rst_n_out, 2'b00);
    check("pulse1_a_done",  if_a.seq_done,  1'b0);
    check("pulse1_a_cause", if_a.rst_cause, 1'b0);
    check("pulse1_b_out",   if_b.rst_n_out, 4'b0000);
    #0.5;
    async_reset_n = 1'b1;

    // Restart, then pulse again at E'+10 (mid-HOLD) and time from the new E''.
    for (int m = 0; m <= 10; m++) begin
      @(posedge clk_core);
      if (m < 10) @(negedge clk_core);
    end
    #2;
    async_reset_n = 1'b0;
    #0.5;
    check("pulse2_a_out", if_a.rst_n_out, 2'b00);
    check("pulse2_b_out", if_b.rst_n_out, 4'b0000);
    #0.5;
    async_reset_n = 1'b1;
    for (int m = 0; m <= 20; m++) begin
      @(posedge clk_core);
      @(negedge clk_core);
      case (m)
        17: check("re_e17", if_a.rst_n_out, 2'b00);
        18: check("re_e18", if_a.rst_n_out, 2'b01);
        19: begin
          check("re_e19", if_a.rst_n_out, 2'b11);
          check("re_e19_done", if_a.seq_done, 1'b1);
        end
        default: ;
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
